// File: rtl/fifo_stream.sv
// fifo_stream: parametrised synchronous FIFO with valid/ready handshakes on
// both sides, arbitrary depth, fill level, almost-full/almost-empty flags and
// a high-water-mark register.
//
// Optional feature macro: FIFO_STREAM_FALL_THROUGH_EN
//   When defined, a word offered to an empty FIFO is presented on the output
//   in the same cycle.
//   - If the consumer takes it, the word bypasses storage entirely.
//   - If the consumer does not take it, the word is written into storage
//     as usual.
//   When undefined, there is no combinational in-to-out path, and the
//   minimum write-to-read latency is one cycle.
//
// Reset is synchronous and active-high. flush_i clears contents and
// statistics. During the flush cycle both handshakes are forced low.

module fifo_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CW-1:0]         usage_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CW-1:0]         max_usage_o
);

    // Index width: at least one bit, even for tiny depths.
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX_C = IW'(DEPTH - 1);
    localparam logic [31:0]   AF_T_C     = AF_THRESH;
    localparam logic [31:0]   AE_T_C     = AE_THRESH;

    // Advance a buffer index.
    // The wrap is an explicit compare, so non-power-of-two depths work.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == LAST_IDX_C) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + IW'(1);
        end
        return nxt;
    endfunction

    // Storage and state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] max_q,    max_d;

    // Handshake and control signals
    logic        full_s;
    logic        empty_s;
    logic        stored_valid_s;
    logic        bypass_s;
    logic        push_s;
    logic        pop_s;
    logic        ft_take_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic [31:0] count_ext_s;

    assign full_s         = (count_q == DEPTH_C);
    assign empty_s        = (count_q == {CW{1'b0}});
    assign stored_valid_s = !empty_s && !flush_i;
    assign count_ext_s    = 32'(count_q);

`ifdef FIFO_STREAM_FALL_THROUGH_EN
    // An empty FIFO exposes the incoming word directly.
    assign bypass_s = empty_s && in_valid_i && !flush_i;
`else
    assign bypass_s = 1'b0;
`endif

    // Ready depends only on local state and flush, never on out_ready_i.
    assign in_ready_o  = !full_s && !flush_i;
    assign out_valid_o = stored_valid_s || bypass_s;

    assign push_s    = in_valid_i && in_ready_o;
    assign pop_s     = out_valid_o && out_ready_i;

    // A bypassed word is consumed on the same cycle.
    // It never touches storage, the indices or the count.
    assign ft_take_s = bypass_s && out_ready_i;
    assign wr_en_s   = push_s && !ft_take_s;
    assign rd_en_s   = pop_s && !ft_take_s;

    // Output data mux: stored head, bypassed input, or zero when idle.
    always_comb begin
        out_data_o = {DATA_WIDTH{1'b0}};
        if (stored_valid_s) begin
            out_data_o = mem_q[rd_idx_q];
        end else if (bypass_s) begin
            out_data_o = in_data_i;
        end else begin
            out_data_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Status outputs are compares on the registered count.
    always_comb begin
        usage_o        = count_q;
        max_usage_o    = max_q;
        almost_full_o  = (count_ext_s >= AF_T_C);
        almost_empty_o = (count_ext_s <= AE_T_C);
    end

    // Next-state for the indices and the count.
    // Flush takes priority over any transfer.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_idx_d = {IW{1'b0}};
            rd_idx_d = {IW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_idx_d = next_idx(wr_idx_q);
            end else begin
                wr_idx_d = wr_idx_q;
            end
            if (rd_en_s) begin
                rd_idx_d = next_idx(rd_idx_q);
            end else begin
                rd_idx_d = rd_idx_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // High-water mark: track the running maximum of the next count.
    // It is cleared by flush.
    always_comb begin
        max_d = max_q;
        if (flush_i) begin
            max_d = {CW{1'b0}};
        end else if (count_d > max_q) begin
            max_d = count_d;
        end else begin
            max_d = max_q;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= {IW{1'b0}};
            rd_idx_q <= {IW{1'b0}};
            count_q  <= {CW{1'b0}};
            max_q    <= {CW{1'b0}};
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    // Payload storage write.
    // Storage is intentionally left unreset, since its contents are only
    // visible through a valid index range.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && wr_en_s) begin
            mem_q[wr_idx_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_fifo_stream.sv
// Self-checking bench for fifo_stream (DATA_WIDTH=8, DEPTH=5, AF=4, AE=1).
//
// Stimulus pushes expected words into a scoreboard queue.
// A negedge monitor pops and compares them whenever the DUT hands out data.
// Expectations for FIFO_STREAM_FALL_THROUGH_EN follow the macro.

module tb_fifo_stream;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] usage_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [CW-1:0] max_usage_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [DW-1:0] sb_q[$];

    fifo_stream #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .AF_THRESH  (4),
        .AE_THRESH  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .usage_o        (usage_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .max_usage_o    (max_usage_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output transfer must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_pop: got data 0x%0h expected no transfer", out_data_o);
            end else begin
                check("out_data", 32'(out_data_o), 32'(sb_q.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus.
    // Entered and left at posedge+1. When iv is set, acc says whether the
    // FIFO is expected to accept the word.
    task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic acc);
        in_valid_i  = iv;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        if (iv && acc) sb_q.push_back(d);
        @(negedge clk);
        if (iv) check("in_ready_cycle", 32'(in_ready_o), 32'(acc));
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", 32'(out_data_o), 32'd0);
        check("rst_usage", 32'(usage_o), 32'd0);
        check("rst_ae", 32'(almost_empty_o), 32'd1);
        check("rst_af", 32'(almost_full_o), 32'd0);
        check("rst_max", 32'(max_usage_o), 32'd0);

        // 1. Fill then drain
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 8'(8'h0F + k), 1'b0, 1'b0, 1'b1);
            check("t1_usage", 32'(usage_o), 32'(k));
            check("t1_af", 32'(almost_full_o), (k >= 4) ? 32'd1 : 32'd0);
            check("t1_ae", 32'(almost_empty_o), (k <= 1) ? 32'd1 : 32'd0);
        end
        check("t1_full_ready", 32'(in_ready_o), 32'd0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check("t1_full_usage", 32'(usage_o), 32'd5);
        check("t1_max", 32'(max_usage_o), 32'd5);
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t1_drained_valid", 32'(out_valid_o), 32'd0);
        check("t1_drained_usage", 32'(usage_o), 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // 2. Wrap across index 4 -> 0
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 8'(8'h9F + k), 1'b0, 1'b0, 1'b1);
            check("t2_usage", 32'(usage_o), 32'(k));
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t2_usage_end", 32'(usage_o), 32'd0);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3. Simultaneous push/pop when full
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1);
        check("t3_usage_full", 32'(usage_o), 32'd5);
        cyc(1'b1, 8'h35, 1'b1, 1'b0, 1'b0);
        check("t3_usage_pop_only", 32'(usage_o), 32'd4);
        check("t3_ready_back", 32'(in_ready_o), 32'd1);
        cyc(1'b1, 8'h36, 1'b1, 1'b0, 1'b1);
        check("t3_usage_both", 32'(usage_o), 32'd4);
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // 4. Flush and high-water mark
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("t4_max_cleared", 32'(max_usage_o), 32'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b1);
        check("t4_max3", 32'(max_usage_o), 32'd3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
        check("t4_usage2", 32'(usage_o), 32'd2);
        check("t4_max_hold", 32'(max_usage_o), 32'd3);
        in_valid_i  = 1'b1;
        in_data_i   = 8'h44;
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        @(negedge clk);
        check("t4_flush_in_ready", 32'(in_ready_o), 32'd0);
        check("t4_flush_out_valid", 32'(out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        sb_q.delete();
        check("t4_usage0", 32'(usage_o), 32'd0);
        check("t4_max0", 32'(max_usage_o), 32'd0);
        check("t4_out_valid0", 32'(out_valid_o), 32'd0);
        cyc(1'b1, 8'h45, 1'b0, 1'b0, 1'b1);
        check("t4_usage_after", 32'(usage_o), 32'd1);
        check("t4_max_after", 32'(max_usage_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 5. Reset mid-stream
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b1);
        check("t5_usage3", 32'(usage_o), 32'd3);
        rst        = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h53;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid_i = 1'b0;
        sb_q.delete();
        check("t5_usage", 32'(usage_o), 32'd0);
        check("t5_out_valid", 32'(out_valid_o), 32'd0);
        check("t5_in_ready", 32'(in_ready_o), 32'd1);
        check("t5_out_data", 32'(out_data_o), 32'd0);
        check("t5_max", 32'(max_usage_o), 32'd0);

        // 6. Empty-FIFO latency (fall-through when enabled)
        in_valid_i  = 1'b1;
        in_data_i   = 8'h5A;
        out_ready_i = 1'b1;
        sb_q.push_back(8'h5A);
        @(negedge clk);
`ifdef FIFO_STREAM_FALL_THROUGH_EN
        check("t6_ft_valid", 32'(out_valid_o), 32'd1);
        check("t6_ft_data", 32'(out_data_o), 32'h5A);
`else
        check("t6_valid_lat", 32'(out_valid_o), 32'd0);
        check("t6_data_idle", 32'(out_data_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
`ifdef FIFO_STREAM_FALL_THROUGH_EN
        check("t6_ft_usage", 32'(usage_o), 32'd0);
`else
        check("t6_usage1", 32'(usage_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        in_valid_i  = 1'b1;
        in_data_i   = 8'h5B;
        out_ready_i = 1'b0;
        sb_q.push_back(8'h5B);
        @(negedge clk);
`ifdef FIFO_STREAM_FALL_THROUGH_EN
        check("t6_ft_valid_nr", 32'(out_valid_o), 32'd1);
        check("t6_ft_data_nr", 32'(out_data_o), 32'h5B);
`else
        check("t6_valid_nr", 32'(out_valid_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        check("t6_usage_stored", 32'(usage_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t6_usage_end", 32'(usage_o), 32'd0);
        check("t6_sb_final", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
